// File: rtl/seg_pipe_adder.sv
// Pipelined segmented two's-complement adder/subtractor: one SEG-bit ripple
// segment per stage, carry registered between stages, operands skewed in and sums deskewed out.

module seg_pipe_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
endmodule

module seg_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    // vld_pipe[k] tracks stage k for k < STAGES; the top bit is out_valid.
    logic [STAGES:0]  vld_pipe;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             ovf_q;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // ain/bin hold the operand bits not yet consumed; the low SEG bits feed this stage.
        logic [WIDTH-k*SEG-1:0] ain;
        logic [WIDTH-k*SEG-1:0] bin;
        logic [SEG-1:0]         ss;
        logic                   ci;
        logic                   co;
        logic [(k+1)*SEG-1:0]   s_q;
        logic                   c_q;

        seg_pipe_seg #(.SEG(SEG)) u_seg (
            .a  (ain[SEG-1:0]),
            .b  (bin[SEG-1:0]),
            .ci (ci),
            .s  (ss),
            .co (co)
        );

        if (k == 0) begin : g_head
            assign ain = a;
            assign bin = b_eff;
            assign ci  = c0;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (ce) begin
                    s_q <= ss;
                    c_q <= co;
                end
            end
        end else begin : g_body
            assign ci = g_stg[k-1].c_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ain <= '0;
                    bin <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (ce) begin
                    ain <= g_stg[k-1].ain[WIDTH-(k-1)*SEG-1:SEG];
                    bin <= g_stg[k-1].bin[WIDTH-(k-1)*SEG-1:SEG];
                    s_q <= {ss, g_stg[k-1].s_q};
                    c_q <= co;
                end
            end
        end

        // The last stage sees the operand MSBs, so overflow is resolved here.
        if (k == STAGES-1) begin : g_last
            always_ff @(posedge clk) begin
                if (!rst_n)
                    ovf_q <= 1'b0;
                else if (ce)
                    ovf_q <= (ain[SEG-1] == bin[SEG-1]) && (ss[SEG-1] != ain[SEG-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (ce) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
            if (vld_pipe[STAGES-1]) begin
                sum  <= g_stg[STAGES-1].s_q;
                cout <= g_stg[STAGES-1].c_q;
                ovf  <= ovf_q;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed bench for seg_pipe_adder: default 16/4 instance plus 8/8 and 32/4
// instances sharing one stimulus bus.
module tb_seg_pipe_adder;
    logic        clk = 1'b0;
    logic        rst_n, ce, in_valid, sub, cin;
    logic [31:0] a32, b32;

    logic        ov8, co8, of8;
    logic [7:0]  s8;
    logic        ov16, co16, of16;
    logic [15:0] s16;
    logic        ov32, co32, of32;
    logic [31:0] s32;

    always #5 clk = ~clk;

    seg_pipe_adder #(.WIDTH(16), .SEG(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
        .a(a32[15:0]), .b(b32[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov16), .sum(s16), .cout(co16), .ovf(of16));

    seg_pipe_adder #(.WIDTH(8), .SEG(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
        .a(a32[7:0]), .b(b32[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov8), .sum(s8), .cout(co8), .ovf(of8));

    seg_pipe_adder #(.WIDTH(32), .SEG(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
        .a(a32), .b(b32), .cin(cin), .sub(sub),
        .out_valid(ov32), .sum(s32), .cout(co32), .ovf(of32));

    int checks = 0;
    int errors = 0;

    logic        hv [64];
    logic [31:0] ha [64];
    logic [31:0] hb [64];
    logic        hs [64];
    logic        hc [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic s, input logic c);
        in_valid = v;
        a32      = av;
        b32      = bv;
        sub      = s;
        cin      = c;
    endtask

    // Returns {ovf, cout, sum} for a w-bit operation.
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic s, input logic c);
        logic [31:0] mask, am, be, sm;
        logic [32:0] full;
        logic        co, ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am   = av & mask;
        be   = (s ? ~bv : bv) & mask;
        full = {1'b0, am} + {1'b0, be} + {32'd0, (s | c)};
        sm   = full[31:0] & mask;
        co   = full[w];
        ov   = (am[w-1] == be[w-1]) && (sm[w-1] != am[w-1]);
        return {ov, co, sm};
    endfunction

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic s, input logic c,
                          input logic [15:0] es, input logic eco, input logic eof);
        drive(1'b1, {16'h0, av}, {16'h0, bv}, s, c);
        tick;
        in_valid = 1'b0;
        chk({tag, " lat0"}, ov16, 0);
        for (int i = 1; i < 4; i++) begin
            tick;
            chk({tag, " lat"}, ov16, 0);
        end
        tick;
        chk({tag, " strobe"}, ov16, 1);
        chk({tag, " result"}, {of16, co16, s16}, {eof, eco, es});
        tick;
        chk({tag, " oneshot"}, ov16, 0);
        chk({tag, " hold"}, {of16, co16, s16}, {eof, eco, es});
    endtask

    task automatic rchk(input string tag, input int w, input int lat, input int t,
                        input logic ov, input logic [33:0] obs);
        logic ev;
        ev = (t >= lat) ? hv[t-lat] : 1'b0;
        chk({tag, " vld"}, ov, ev);
        if (ev)
            chk({tag, " res"}, obs, model(w, ha[t-lat], hb[t-lat], hs[t-lat], hc[t-lat]));
    endtask

    initial begin
        int   cnt;
        logic v;

        rst_n = 1'b0;
        ce    = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset held with valid traffic on the inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick;
            chk("reset16", {ov16, co16, of16, s16}, 0);
            chk("reset8 vld", ov8, 0);
            chk("reset32 vld", ov32, 0);
        end
        rst_n = 1'b1;

        run_op("add carry chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add ovf",         16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add cin",         16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0);
        run_op("sub borrow",      16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub ovf",         16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Stall with the first result on the output and two more in flight
        drive(1'b1, 32'h00FF, 32'h0F01, 1'b0, 1'b0); tick;
        drive(1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0); tick;
        drive(1'b1, 32'h8000, 32'h8000, 1'b0, 1'b1); tick;
        in_valid = 1'b0;
        tick;
        chk("stall pre", ov16, 0);
        tick;
        chk("stall A vld", ov16, 1);
        chk("stall A", {of16, co16, s16}, {1'b0, 1'b0, 16'h1000});
        ce = 1'b0;
        drive(1'b1, 32'h1111, 32'h2222, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("stall frozen vld", ov16, 1);
            chk("stall frozen", {of16, co16, s16}, {1'b0, 1'b0, 16'h1000});
        end
        ce = 1'b1;
        in_valid = 1'b0;
        tick;
        chk("stall B vld", ov16, 1);
        chk("stall B", {of16, co16, s16}, {1'b0, 1'b0, 16'hF000});
        tick;
        chk("stall C vld", ov16, 1);
        chk("stall C", {of16, co16, s16}, {1'b1, 1'b1, 16'h0001});
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall no dup", ov16, 0);
        end

        // Reset for one cycle (with ce low) while three operations are in flight
        drive(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0); tick;
        drive(1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0); tick;
        drive(1'b1, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0); tick;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        ce    = 1'b0;
        rst_n = 1'b0;
        tick;
        chk("midreset clear", {ov16, co16, of16, s16}, 0);
        rst_n = 1'b1;
        ce    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("midreset16 vld", ov16, 0);
            chk("midreset32 vld", ov32, 0);
            chk("midreset8 vld", ov8, 0);
        end

        // Random mixed traffic with gaps, checked on all three widths
        cnt = 0;
        for (int t = 0; t < 60; t++) begin
            v = (cnt < 20) && ($urandom_range(0, 3) != 0);
            drive(v, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            hv[t] = v;
            ha[t] = a32;
            hb[t] = b32;
            hs[t] = sub;
            hc[t] = cin;
            if (v) cnt++;
            tick;
            rchk("rand8",  8,  1, t, ov8,  {of8, co8, 24'h0, s8});
            rchk("rand16", 16, 4, t, ov16, {of16, co16, 16'h0, s16});
            rchk("rand32", 32, 8, t, ov32, {of32, co32, s32});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
- Parametrised, pipelined, segmented two's-complement adder/subtractor.
- Successor to the single-bit structural full adder. Splits a WIDTH-bit operation into SEG-bit ripple segments, one segment per pipeline stage, with the carry registered between stages.
- Accepts one operation per clock. Provides valid tracking, a global clock-enable stall, and carry-out / signed-overflow flags.
- Used as the arithmetic building block for wider datapaths that need timing closure at high clock rates.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be a multiple of SEG.
- SEG, 4: segment width in bits, i.e. bits added per pipeline stage. Derived STAGES = WIDTH/SEG, must be ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- ce  input  1  clock enable. When 0 the whole pipeline holds.
- in_valid  input  1  qualifies a, b, cin and sub this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Used in add mode only.
- sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b).
- out_valid  output  1  one-cycle strobe when a result appears on sum, cout and ovf.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow of the result.

Behaviour:
- Reset: on a rising edge with rst_n=0, all of the following clear to 0, regardless of ce:
  - out_valid, sum, cout, ovf;
  - every stage valid bit, carry register, skew register and partial-sum register.
- Operand conditioning at stage 0:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin. cin is ignored when sub=1.
- Stage k (k = 0..STAGES-1):
  - Adds segment k of a and b_eff, [k*SEG +: SEG], plus the carry registered by stage k-1 (c0 for stage 0).
  - Registers the SEG-bit partial sum and the carry-out.
  - Upper operand segments travel through skew registers. Completed lower sum segments travel through deskew registers, so all segments of one operation leave the pipeline together.
- Per-stage valid bit accompanies the data. sub and the sign bits needed for ovf are carried with the operation.
- Latency:
  - A result issued with in_valid=1 on edge N (ce=1 throughout) appears with out_valid=1 after edge N+STAGES.
  - Default parameters give a latency of 4 cycles.
- Throughput: one operation per cycle. Back-to-back in_valid produces back-to-back out_valid.
- Output registers (sum, cout, ovf) load only when the last stage holds a valid operation and ce=1. Otherwise they keep the last valid result.
- out_valid:
  - Is 1 for exactly the cycle after such a load.
  - Is 0 on any edge where ce=1 and the last stage holds a bubble.
- ce=0: no register changes, including out_valid, which holds its value. Operations are neither lost nor duplicated.
- in_valid=0 with ce=1: a bubble enters the pipeline. Data registers may load don't-care values, but only the valid bit is architecturally visible.
- Arithmetic rules:
  - sum = (a + b_eff + c0) mod 2^WIDTH.
  - cout = bit WIDTH of that full-precision sum.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Wrap-around: the result simply wraps mod 2^WIDTH, with cout and ovf flagged. No saturation.
- Reset mid-operation: all in-flight operations are discarded. No out_valid is produced for them after reset is released.
- Reset with ce=0: reset still takes effect.
- STAGES=1 (SEG=WIDTH): degenerates to a single registered adder with latency 1. It must still synthesise and be correct.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while driving in_valid=1 and random operands → out_valid=0 and sum=cout=ovf=0 throughout. After release, the first out_valid occurs exactly 4 cycles after the first accepted in_valid.
- Add with carry chain across all segments: a=16'hFFFF, b=16'h0001, cin=0, sub=0 → 4 cycles later sum=16'h0000, cout=1, ovf=0. Then a=16'h7FFF, b=16'h0001 → sum=16'h8000, cout=0, ovf=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 (cin must be ignored) → sum=16'hFFFE, cout=0, ovf=0. Then a=16'h8000, b=16'h0001 → sum=16'h7FFF, cout=1, ovf=1.
- Throughput and ordering: 20 consecutive random operations, mixed add/sub, with in_valid gaps → out_valid pattern equals the input pattern delayed by 4 cycles, and every result matches the reference model.
- Stall: issue 3 operations, then drop ce for 5 cycles mid-flight → outputs and out_valid frozen during the stall. After ce returns, the 3 results emerge in order, each exactly once.
- Reset mid-operation and parameter sweep:
  - Assert rst_n=0 for 1 cycle while 3 operations are in flight → none of them produce out_valid.
  - Rerun the random test with (WIDTH=8, SEG=8) and (WIDTH=32, SEG=4) → latency 1 and 8 respectively, all results correct.
